// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving one Montgomery multiplier.
// Define MODEXP_SKIP_LZ_EN to skip leading zero exponent bits before the first job.
module modexp_ctrl #(
  parameter int EXP_W   = 256,
  parameter int TIMEOUT = 64,
  parameter int DATA_W  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [EXP_W-1:0]  exponent,
  input  logic [DATA_W-1:0] base_mont,
  input  logic [DATA_W-1:0] mont_one,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result,
  output logic              mm_enable,
  output logic              mm_pow_bit,
  output logic [DATA_W-1:0] mm_multiplicand,
  output logic [DATA_W-1:0] mm_indata,
  input  logic              mm_endflag,
  input  logic [DATA_W-1:0] mm_result
);
  localparam int BW = $clog2(EXP_W + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [BW-1:0] BIT_ALL = BW'(EXP_W);
  localparam logic [BW-1:0] BIT_ONE = BW'(1);

  typedef enum logic [2:0] {
`ifdef MODEXP_SKIP_LZ_EN
    S_SCAN,
`endif
    S_IDLE, S_LOAD, S_RUN, S_DONE
  } state_t;

  state_t            state;
  logic [EXP_W-1:0]  exp_sh;
  logic [DATA_W-1:0] base_r;
  logic [DATA_W-1:0] acc;
  logic [BW-1:0]     bit_cnt;
  logic [TW-1:0]     to_cnt;

  // Multiplier operands are the working registers themselves, so they stay
  // stable across LOAD and RUN without extra staging.
  assign mm_multiplicand = acc;
  assign mm_indata       = base_r;
  assign mm_pow_bit      = exp_sh[EXP_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      exp_sh    <= '0;
      base_r    <= '0;
      acc       <= '0;
      bit_cnt   <= '0;
      to_cnt    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      result    <= '0;
      mm_enable <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          exp_sh  <= exponent;
          base_r  <= base_mont;
          acc     <= mont_one;
          bit_cnt <= BIT_ALL;
          err     <= 1'b0;
          busy    <= 1'b1;
`ifdef MODEXP_SKIP_LZ_EN
          state   <= S_SCAN;
`else
          state   <= S_LOAD;
`endif
        end
`ifdef MODEXP_SKIP_LZ_EN
        S_SCAN: begin
          if (bit_cnt == '0) begin
            // all-zero exponent: result is the untouched Montgomery one
            result <= acc;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= S_DONE;
          end else if (!exp_sh[EXP_W-1]) begin
            exp_sh  <= exp_sh << 1;
            bit_cnt <= bit_cnt - 1'b1;
          end else begin
            state <= S_LOAD;
          end
        end
`endif
        S_LOAD: begin
          mm_enable <= 1'b1;
          to_cnt    <= '0;
          state     <= S_RUN;
        end
        S_RUN: begin
          to_cnt <= to_cnt + 1'b1;
          if (mm_endflag) begin
            acc       <= mm_result;
            exp_sh    <= exp_sh << 1;
            bit_cnt   <= bit_cnt - 1'b1;
            mm_enable <= 1'b0;
            if (bit_cnt == BIT_ONE) begin
              result <= mm_result;
              busy   <= 1'b0;
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              state <= S_LOAD;
            end
          end else if (to_cnt == TO_LAST) begin
            err       <= 1'b1;
            result    <= acc;
            mm_enable <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_modexp_ctrl.sv
// Randomized bench for modexp_ctrl: EXP_W=8, 18-cycle multiplier stub computing
// m*m*(pow_bit ? b : 1) mod 101, checked against a whole-operation power model.
module tb_modexp_ctrl;
  localparam int EXP_W = 8, TIMEOUT = 64, DATA_W = 16, LAT = 18, P = 101;

  logic              clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [EXP_W-1:0]  exponent = '0;
  logic [DATA_W-1:0] base_mont = '0, mont_one = '0;
  logic              busy, done, err, mm_enable, mm_pow_bit, mm_endflag;
  logic [DATA_W-1:0] result, mm_multiplicand, mm_indata, mm_result;

  modexp_ctrl #(.EXP_W(EXP_W), .TIMEOUT(TIMEOUT), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .exponent(exponent),
    .base_mont(base_mont), .mont_one(mont_one), .busy(busy), .done(done),
    .err(err), .result(result), .mm_enable(mm_enable), .mm_pow_bit(mm_pow_bit),
    .mm_multiplicand(mm_multiplicand), .mm_indata(mm_indata),
    .mm_endflag(mm_endflag), .mm_result(mm_result));

  always #5 clk = ~clk;

  // multiplier stub: one result per mm_enable high period, LAT cycles after rise
  logic              hang = 1'b0, spur = 1'b0, mdl_flag;
  logic [DATA_W-1:0] spur_val = '0, mdl_res;
  int                mcnt;
  logic              fired;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt <= 0; fired <= 1'b0; mdl_flag <= 1'b0; mdl_res <= '0;
    end else begin
      mdl_flag <= 1'b0;
      if (!mm_enable) begin
        mcnt <= 0; fired <= 1'b0;
      end else if (!fired && !hang) begin
        if (mcnt == LAT - 1) begin
          mdl_flag <= 1'b1;
          mdl_res  <= DATA_W'((int'(mm_multiplicand) * int'(mm_multiplicand) % P)
                      * (mm_pow_bit ? int'(mm_indata) : 1) % P);
          fired    <= 1'b1;
        end else mcnt <= mcnt + 1;
      end
    end
  end
  assign mm_endflag = mdl_flag | spur;
  assign mm_result  = spur ? spur_val : mdl_res;

  int cyc = 0, rises = 0, first_run = -1;
  logic prev_en = 1'b0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    prev_en <= mm_enable;
    if (mm_enable && !prev_en) begin
      rises <= rises + 1;
      if (first_run < 0) first_run <= cyc;
    end
  end

  int vectors = 0, miscompares = 0;
  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int ref_pow(input int b, input int e);
    int r = 1;
    for (int i = EXP_W - 1; i >= 0; i--) begin
      r = r * r % P;
      if ((e >> i) & 1) r = r * b % P;
    end
    return r;
  endfunction

  function automatic int exp_jobs(input int e);
`ifdef MODEXP_SKIP_LZ_EN
    int n = 0;
    for (int i = 0; i < EXP_W; i++) if ((e >> i) & 1) n = i + 1;
    return n;
`else
    return EXP_W;
`endif
  endfunction

  // issue one operation, wait for done; returns cycles and rises seen
  task automatic run_op(input int e, input int b, input bit poke_busy,
                        output int got_done, output int nrise);
    int r0;
    @(negedge clk);
    r0 = rises;
    exponent = EXP_W'(e); base_mont = DATA_W'(b); mont_one = 1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got_done = 0;
    for (int i = 0; i < 400; i++) begin
      if (poke_busy && i == 30) begin
        exponent = ~exponent; base_mont = base_mont + 1; start = 1'b1;
      end else start = 1'b0;
      if (done) begin got_done = 1; break; end
      @(negedge clk);
    end
    start = 1'b0;
    nrise = rises - r0;
  endtask

  initial begin
    int gd, nr, e, b, t0;
    #1;
    chk("reset_busy", busy, 0); chk("reset_done", done, 0);
    chk("reset_en", mm_enable, 0); chk("reset_result", result, 0);
    chk("reset_acc", mm_multiplicand, 0);
    #13 rst_n = 1'b1;

    run_op(8'h0D, 3, 1'b0, gd, nr);
    chk("basic_done", gd, 1); chk("basic_result", result, 38);
    chk("basic_err", err, 0); chk("basic_rises", nr, exp_jobs(8'h0D));

    // back-to-back randomized operations, one with a start poked while busy
    for (int k = 0; k < 12; k++) begin
      e = (k == 0) ? 0 : (k == 1) ? 8'hFF : (k == 2) ? 1 : int'($urandom_range(0, 255));
      b = int'($urandom_range(1, P - 1));
      run_op(e, b, k == 3, gd, nr);
      chk($sformatf("rand%0d_done", k), gd, 1);
      chk($sformatf("rand%0d_result", k), result, ref_pow(b, e));
      chk($sformatf("rand%0d_err", k), err, 0);
      chk($sformatf("rand%0d_rises", k), nr, exp_jobs(e));
    end

    // spurious endflag while idle must not disturb the accumulator
    @(negedge clk);
    t0 = mm_multiplicand;
    spur_val = 16'h1234; spur = 1'b1;
    @(negedge clk); spur = 1'b0;
    @(negedge clk);
    chk("spur_acc", mm_multiplicand, t0); chk("spur_busy", busy, 0);

    // timeout: done exactly TIMEOUT cycles after the first RUN cycle
    hang = 1'b1;
    @(negedge clk); first_run = -1;
    run_op(8'h80, 5, 1'b0, gd, nr);
    chk("to_done", gd, 1); chk("to_err", err, 1);
    chk("to_latency", cyc - first_run, TIMEOUT);
    @(negedge clk);
    chk("to_busy_after", busy, 0);
    hang = 1'b0;

    // reset during the third job
    @(negedge clk);
    t0 = rises;
    exponent = 8'h0D; base_mont = 3; mont_one = 1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 200 && rises < t0 + 3; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_en", mm_enable, 0); chk("rst_busy", busy, 0);
    chk("rst_done", done, 0); chk("rst_result", result, 0);
    chk("rst_err", err, 0); chk("rst_acc", mm_multiplicand, 0);
    gd = 0;
    repeat (4) @(negedge clk) if (done) gd = 1;
    chk("rst_no_done", gd, 0);
    rst_n = 1'b1;
    run_op(8'h0D, 3, 1'b0, gd, nr);
    chk("post_rst_done", gd, 1); chk("post_rst_result", result, 38);

`ifdef MODEXP_SKIP_LZ_EN
    @(negedge clk); t0 = cyc;
    run_op(0, 7, 1'b0, gd, nr);
    chk("lz_zero_fast", (cyc - t0) <= 11 ? 1 : 0, 1);
    chk("lz_zero_rises", nr, 0); chk("lz_zero_result", result, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/modexp_ctrl.md
Name: modexp_ctrl

Overview:
- Initiator that drives one Montgomery multiply/square unit through a full left-to-right square-and-multiply modular exponentiation.
- Latches the exponent, the base (already in Montgomery domain) and the Montgomery one (R mod N).
- Scans the exponent MSB-first and issues one multiplier job per exponent bit, with pow_bit equal to that bit.
- Captures each job's result as the next multiplicand. Sits between the RSA top-level sequencer and the multiplier.

Parameters:
- EXP_W, 256, exponent width in bits; also the number of multiplier jobs per operation when leading-zero skip is off.
- TIMEOUT, 64, maximum cycles to wait for mm_endflag per job before aborting with err.
- DATA_W, 256, operand/result width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- exponent  in  EXP_W  exponent e, sampled on accepted start
- base_mont  in  DATA_W  base in Montgomery domain, sampled on accepted start
- mont_one  in  DATA_W  R mod N, initial accumulator, sampled on accepted start
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; 1 = multiplier timeout
- result  out  DATA_W  final accumulator, held until next accepted start
- mm_enable  out  1  multiplier run control; low = load/clear, high = run
- mm_pow_bit  out  1  current exponent bit
- mm_multiplicand  out  DATA_W  accumulator register
- mm_indata  out  DATA_W  latched base_mont
- mm_endflag  in  1  multiplier completion pulse
- mm_result  in  DATA_W  multiplier output, valid when mm_endflag=1

Behaviour:
- Clock and reset: clk and rst_n, one clock; reset is asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, acc=0, exp_sh=0, bit_cnt=0, to_cnt=0. Reset mid-operation aborts immediately, with mm_enable=0 and no done.
- IDLE, start=1:
  - exp_sh<=exponent; base_r<=base_mont; acc<=mont_one; bit_cnt<=EXP_W; err<=0.
  - Go to LOAD; busy=1 from the next cycle.
  - start while busy is ignored.
- LOAD: mm_enable=0 for exactly one cycle, so the multiplier clears and loads acc.
  - mm_multiplicand=acc, mm_indata=base_r and mm_pow_bit=exp_sh[EXP_W-1] are stable from LOAD through the end of RUN.
  - Go to RUN; to_cnt<=0.
- RUN: mm_enable=1; to_cnt increments each cycle.
  - On mm_endflag=1: acc<=mm_result; exp_sh<=exp_sh<<1; bit_cnt<=bit_cnt-1. If bit_cnt==1, go to DONE; else go to LOAD.
  - If to_cnt==TIMEOUT-1 and mm_endflag=0: err<=1, go to DONE, acc unchanged.
  - mm_endflag and the timeout in the same cycle: endflag wins.
- DONE: mm_enable=0, done=1 for one cycle, result<=acc (registered on the DONE transition), busy=0; go to IDLE.
- mm_endflag outside RUN is ignored. Back-to-back start on the cycle after done is accepted.
- Exponent 0 without skip: EXP_W squarings of mont_one; result=mont_one.
- Per job latency = 1 (LOAD) + multiplier latency. Total = EXP_W jobs + 2 cycles overhead (accept + DONE).
- Widths: bit_cnt is clog2(EXP_W+1) bits, to_cnt is clog2(TIMEOUT) bits, with no wrap in normal operation.

Optional Feature:
- Macro: MODEXP_SKIP_LZ_EN.
- Defined: adds a SCAN state between accept and the first LOAD.
  - While exp_sh[EXP_W-1]==0 and bit_cnt!=0: shift exp_sh left by one and decrement bit_cnt, one bit per cycle, with no multiplier job.
  - If bit_cnt reaches 0 (exponent==0): go directly to DONE with result=mont_one, err=0, and mm_enable never raised.
- Undefined: no SCAN state; every one of the EXP_W bits issues a job.

Test Plan:
- Bench setup: EXP_W=8 and a behavioural multiplier model with 18-cycle latency. The model returns (m*m*(pow_bit?b:1)) mod 101, so mont_one=1.
- Basic run: base=3, exponent=8'h0D, start -> done after 8 jobs, result=38, err=0. Exactly 8 mm_enable rising edges, each preceded by ≥1 cycle of mm_enable=0.
- MODEXP_SKIP_LZ_EN defined, same stimulus -> result=38 with 4 mm_enable rising edges. Exponent 0 -> done within 10 cycles, result=1, no mm_enable rise.
- Timeout: model never pulses endflag -> done with err=1 exactly TIMEOUT cycles after the first RUN entry; busy=0 afterwards.
- Reset mid-run: assert rst_n=0 during job 3 -> all outputs 0 asynchronously, no done. A new start after release gives a correct result of 38.
- Protocol robustness: start pulsed while busy has no effect. A spurious mm_endflag in IDLE leaves acc unchanged. Start on the cycle after done is accepted, and its result is correct.
